muldiv_iter: RTL and testbench
==============================

// Module: muldiv_iter
// PURPOSE
//  Multi-cycle RV64M multiply/divide execution unit for the backend exu. It replaces the
//  combinational muldiv slot with a valid/ready unit that holds one operation in flight.
//  - Multiply: operand registers plus a MUL_LAT-cycle pipeline.
//  - Divide: radix-2 restoring divider.
//  Carries rob/rd tags through to writeback. Supports flush on redirect.
// PARAMETERS
//  XLEN      64  operand/result width (32 or 64); W-ops only legal when XLEN==64
//  MUL_LAT   3   cycles from accept to out_valid for MUL*; legal range 1..8
//  TAG_W     6   width of rob_idx tag carried through
// PORTS
//  clock         in   1        rising-edge clock
//  reset         in   1        synchronous, active-high reset
//  flush         in   1        kill in-flight op (branch redirect / exception)
//  in_valid      in   1        request valid
//  in_ready      out  1        unit can accept (IDLE only)
//  muldiv_type   in   4        0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//                              8 MULW 12 DIVW 13 DIVUW 14 REMW 15 REMUW; 9-11 illegal
//  src1          in   XLEN     rs1 operand
//  src2          in   XLEN     rs2 operand
//  rd            in   5        destination logical reg, passed through
//  need_to_wb    in   1        passed through
//  rob_idx       in   TAG_W    passed through
//  out_valid     out  1        result valid, held until out_ready
//  out_ready     in   1        consumer accepts result
//  result        out  XLEN     result
//  out_rd        out  5        tag of completed op
//  out_need_to_wb out 1        tag of completed op
//  out_rob_idx   out  TAG_W    tag of completed op
// BEHAVIOUR
//  Reset
//  - State IDLE; out_valid=0, in_ready=1; result, tags and counters = 0.
//  Handshake and state machine
//  - Accept in cycle T when in_valid & in_ready & !flush; operands and tags are latched.
//  - States: IDLE -> MUL | DIV | DONE.
//  - MUL | DIV -> DONE; DONE -> IDLE on out_ready.
//  - in_ready = (state==IDLE); there is no same-cycle DONE->accept bypass.
//  MUL path
//  - out_valid rises at T+MUL_LAT.
//  - MULH/HSU/HU return bits [2*XLEN-1:XLEN] of the signed/signed-unsigned/unsigned product.
//  - MUL returns the low XLEN bits.
//  - MULW returns the low 32 bits of the product, sign-extended to 64.
//  DIV path
//  - Signed ops take the absolute values of the operands.
//  - N = 32 for W-ops (operands are src[31:0], sign- or zero-extended per op), else N = XLEN.
//  - One quotient bit per cycle, counter N-1..0; out_valid rises at T+N+1.
//  - Quotient sign = sign1 ^ sign2; remainder sign = sign of dividend.
//  - W-op results are sign-extended from bit 31 (DIVUW/REMUW included).
//  Special cases (go straight to DONE, out_valid at T+1)
//  - Divide by zero: quotient = all ones; remainder = dividend.
//  - Signed overflow (dividend = most negative, divisor = -1): quotient = dividend; remainder = 0.
//  - W-ops apply both rules on 32 bits, then sign-extend.
//  Output stability
//  - While out_valid & !out_ready: result and out_* tags are held stable; no new accept.
//  Flush
//  - Flush in any state: state <= IDLE next cycle, out_valid <= 0, counters cleared.
//  - A result pending in DONE is discarded.
//  - Flush has priority over in_valid in the same cycle (no accept).
//  - Flush and out_ready together in DONE: the result is counted as consumed; the flush is harmless.
//  Other rules
//  - Illegal muldiv_type: behaves as MUL (no trap).
//  - Reset mid-operation has the same effect as flush, plus outputs cleared.
// TESTING
//  1. XLEN=64, MUL_LAT=3: MUL src1=7 src2=-3 at T -> out_valid@T+3, result=0xFFFF_FFFF_FFFF_FFEB.
//  2. DIV 100/7 at T -> out_valid@T+65, result=14; REM same operands -> 2; REMU -100/7 correct unsigned.
//  3. DIV x/0 -> result=all ones @T+1; REMW 0x8000_0000 by -1 -> 0;
//     DIVW 0x8000_0000 by -1 -> 0xFFFF_FFFF_8000_0000.
//  4. MULHU all-ones * all-ones -> 0xFFFF_FFFF_FFFF_FFFE; MULW 0x7FFF_FFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE.
//  5. Flush at T+10 of a DIV -> no out_valid ever; in_ready=1 @T+11; new MUL accepted completes normally.
//  6. out_ready low 5 cycles after out_valid -> result/tags stable, in_ready=0;
//     out_ready=1 -> IDLE next cycle, rob_idx tag matches accepted request.

Source files
------------

// File: rtl/muldiv_iter_if.sv
// Issue/writeback bundle of the iterative multiply/divide unit.
interface muldiv_iter_if #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned TAG_W = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       muldiv_type;
   logic [XLEN-1:0]  src1;
   logic [XLEN-1:0]  src2;
   logic [4:0]       rd;
   logic             need_to_wb;
   logic [TAG_W-1:0] rob_idx;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  result;
   logic [4:0]       out_rd;
   logic             out_need_to_wb;
   logic [TAG_W-1:0] out_rob_idx;

   modport master (
      output in_valid, muldiv_type, src1, src2, rd, need_to_wb, rob_idx, out_ready,
      input  in_ready, out_valid, result, out_rd, out_need_to_wb, out_rob_idx
   );

   modport slave (
      input  in_valid, muldiv_type, src1, src2, rd, need_to_wb, rob_idx, out_ready,
      output in_ready, out_valid, result, out_rd, out_need_to_wb, out_rob_idx
   );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV64M multiply/divide unit: one op in flight, MUL_LAT-cycle multiply,
// radix-2 restoring divide, rob/rd tags carried through to writeback.
module muldiv_iter #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned TAG_W   = 6
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   muldiv_iter_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [XLEN-1:0]  result_q;
   logic [4:0]       rd_q;
   logic             need_to_wb_q;
   logic [TAG_W-1:0] rob_idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  src1_q;
   logic [XLEN-1:0]  src2_q;
   logic [1:0]       mul_kind_q;
   logic             mul_w_q;
   logic [XLEN-1:0]  dvd_q;
   logic [XLEN-1:0]  dsr_q;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  quo_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             div_rem_q;
   logic             div_w_q;

   function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
      return XLEN'($signed(v[31:0]));
   endfunction

   // Opcode decode; 9-11 fall through to plain MUL.
   logic [3:0] op_c;
   logic       in_div_c;
   logic       in_w_c;
   logic       in_signed_c;
   logic       in_rem_c;
   logic [1:0] in_mul_kind_c;

   always_comb begin
      op_c          = bus.muldiv_type;
      in_div_c      = op_c[2];
      in_w_c        = (XLEN == 64) && op_c[3] && (op_c[2] || (op_c[1:0] == 2'd0));
      in_mul_kind_c = op_c[3] ? 2'd0 : op_c[1:0];
      in_signed_c   = ~op_c[0];
      in_rem_c      = op_c[1];
   end

   // Divide setup: extended operands, magnitudes and the single-cycle special cases.
   logic [XLEN-1:0] x_c, y_c, min_c, mag1_c, mag2_c, special_c;
   logic            s1_c, s2_c, div_zero_c, div_ovf_c;

   always_comb begin
      x_c   = bus.src1;
      y_c   = bus.src2;
      min_c = {1'b1, {(XLEN-1){1'b0}}};
      if (in_w_c) begin
         x_c   = in_signed_c ? sext_w(bus.src1) : XLEN'(bus.src1[31:0]);
         y_c   = in_signed_c ? sext_w(bus.src2) : XLEN'(bus.src2[31:0]);
         min_c = ~XLEN'(32'h7FFF_FFFF);
      end
      s1_c       = in_signed_c & x_c[XLEN-1];
      s2_c       = in_signed_c & y_c[XLEN-1];
      mag1_c     = s1_c ? -x_c : x_c;
      mag2_c     = s2_c ? -y_c : y_c;
      div_zero_c = (y_c == '0);
      div_ovf_c  = in_signed_c && (x_c == min_c) && (y_c == '1);
      if (div_zero_c) special_c = in_rem_c ? x_c : '1;
      else            special_c = in_rem_c ? '0  : x_c;
      if (in_w_c) special_c = sext_w(special_c);
   end

   // One restoring step per cycle; the final step also applies the result signs.
   logic [XLEN:0]   rem_sh_c;
   logic            quo_bit_c;
   logic [XLEN-1:0] rem_nx_c, quo_nx_c, div_res_c;

   always_comb begin
      rem_sh_c  = {rem_q, dvd_q[cnt_q]};
      quo_bit_c = (rem_sh_c >= {1'b0, dsr_q});
      rem_nx_c  = quo_bit_c ? (rem_sh_c[XLEN-1:0] - dsr_q) : rem_sh_c[XLEN-1:0];
      quo_nx_c  = {quo_q[XLEN-2:0], quo_bit_c};
      if (div_rem_q) div_res_c = neg_rem_q ? -rem_nx_c : rem_nx_c;
      else           div_res_c = neg_quo_q ? -quo_nx_c : quo_nx_c;
      if (div_w_q) div_res_c = sext_w(div_res_c);
   end

   // Multiplier reads live inputs when it must finish in the accept cycle.
   logic [XLEN-1:0]   mul_a_c, mul_b_c, mul_res_c;
   logic [1:0]        mul_kind_c;
   logic              mul_w_c;
   logic [2*XLEN-1:0] mul_ae_c, mul_be_c, prod_c;

   always_comb begin
      mul_a_c    = src1_q;
      mul_b_c    = src2_q;
      mul_kind_c = mul_kind_q;
      mul_w_c    = mul_w_q;
      if (MUL_LAT == 1) begin
         mul_a_c    = bus.src1;
         mul_b_c    = bus.src2;
         mul_kind_c = in_mul_kind_c;
         mul_w_c    = in_w_c;
      end
      mul_ae_c = ((mul_kind_c == 2'd1) || (mul_kind_c == 2'd2)) ?
                 {{XLEN{mul_a_c[XLEN-1]}}, mul_a_c} : {{XLEN{1'b0}}, mul_a_c};
      mul_be_c = (mul_kind_c == 2'd1) ?
                 {{XLEN{mul_b_c[XLEN-1]}}, mul_b_c} : {{XLEN{1'b0}}, mul_b_c};
      prod_c    = mul_ae_c * mul_be_c;
      mul_res_c = (mul_kind_c == 2'd0) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
      if (mul_w_c) mul_res_c = sext_w(prod_c[XLEN-1:0]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         result_q     <= '0;
         rd_q         <= '0;
         need_to_wb_q <= 1'b0;
         rob_idx_q    <= '0;
         cnt_q        <= '0;
         src1_q       <= '0;
         src2_q       <= '0;
         mul_kind_q   <= '0;
         mul_w_q      <= 1'b0;
         dvd_q        <= '0;
         dsr_q        <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         neg_quo_q    <= 1'b0;
         neg_rem_q    <= 1'b0;
         div_rem_q    <= 1'b0;
         div_w_q      <= 1'b0;
      end else if (flush) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  in_ready_q   <= 1'b0;
                  rd_q         <= bus.rd;
                  need_to_wb_q <= bus.need_to_wb;
                  rob_idx_q    <= bus.rob_idx;
                  src1_q       <= bus.src1;
                  src2_q       <= bus.src2;
                  mul_kind_q   <= in_mul_kind_c;
                  mul_w_q      <= in_w_c;
                  if (in_div_c) begin
                     if (div_zero_c || div_ovf_c) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= special_c;
                     end else begin
                        state_q   <= S_DIV;
                        cnt_q     <= in_w_c ? CNT_W'(31) : CNT_W'(XLEN - 1);
                        dvd_q     <= mag1_c;
                        dsr_q     <= mag2_c;
                        rem_q     <= '0;
                        quo_q     <= '0;
                        neg_quo_q <= s1_c ^ s2_c;
                        neg_rem_q <= s1_c;
                        div_rem_q <= in_rem_c;
                        div_w_q   <= in_w_c;
                     end
                  end else if (MUL_LAT == 1) begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= mul_res_c;
                  end else begin
                     state_q <= S_MUL;
                     cnt_q   <= CNT_W'(MUL_LAT - 2);
                  end
               end
            end
            S_MUL: begin
               if (cnt_q == '0) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= mul_res_c;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DIV: begin
               rem_q <= rem_nx_c;
               quo_q <= quo_nx_c;
               if (cnt_q == '0) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= div_res_c;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.result         = result_q;
   assign bus.out_rd         = rd_q;
   assign bus.out_need_to_wb = need_to_wb_q;
   assign bus.out_rob_idx    = rob_idx_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized bench for muldiv_iter against an arithmetic reference model.
module tb_muldiv_iter;
   localparam int unsigned XLEN    = 64;
   localparam int unsigned MUL_LAT = 3;
   localparam int unsigned TAG_W   = 6;
   localparam logic [63:0] MIN64   = 64'h8000_0000_0000_0000;

   logic clock = 1'b0;
   logic reset;
   logic flush;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clock = ~clock;

   muldiv_iter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   muldiv_iter #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // Reference: RISC-V M-extension semantics in plain arithmetic.
   function automatic logic [63:0] ref_result(input logic [3:0] t, input logic [63:0] a,
                                               input logic [63:0] b);
      logic signed [127:0] sa, sb;
      logic [127:0]        ua, ub, p;
      logic [31:0]         a32, b32, r32;
      logic                ovf, ovf32;
      sa  = 128'($signed(a));
      sb  = 128'($signed(b));
      ua  = 128'(a);
      ub  = 128'(b);
      a32 = a[31:0];
      b32 = b[31:0];
      ovf   = (a == MIN64) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
      ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
      r32 = 32'd0;
      case (t)
         4'd1: begin p = sa * sb; return p[127:64]; end
         4'd2: begin p = sa * ub; return p[127:64]; end
         4'd3: begin p = ua * ub; return p[127:64]; end
         4'd4: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf ? a : 64'($signed(a) / $signed(b));
         4'd5: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
         4'd6: return (b == 0) ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
         4'd7: return (b == 0) ? a : a % b;
         4'd8: r32 = a32 * b32;
         4'd12: r32 = (b32 == 0) ? 32'hFFFF_FFFF : ovf32 ? a32 : 32'($signed(a32) / $signed(b32));
         4'd13: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
         4'd14: r32 = (b32 == 0) ? a32 : ovf32 ? 32'd0 : 32'($signed(a32) % $signed(b32));
         4'd15: r32 = (b32 == 0) ? a32 : a32 % b32;
         default: return a * b;
      endcase
      return 64'($signed(r32));
   endfunction

   function automatic int ref_lat(input logic [3:0] t, input logic [63:0] a, input logic [63:0] b);
      if (t inside {4'd4, 4'd5, 4'd6, 4'd7}) begin
         if (b == 0 || (t inside {4'd4, 4'd6} && a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF))
            return 1;
         return 65;
      end
      if (t inside {4'd12, 4'd13, 4'd14, 4'd15}) begin
         if (b[31:0] == 0 ||
             (t inside {4'd12, 4'd14} && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
            return 1;
         return 33;
      end
      return int'(MUL_LAT);
   endfunction

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'd1;
         2: return 64'hFFFF_FFFF_FFFF_FFFF;
         3: return MIN64;
         4: return 64'hFFFF_FFFF_8000_0000;
         5: return {32'($urandom), 32'h8000_0000};
         6: return 64'($urandom_range(0, 1000));
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   // Issue one op, check latency/result/tags, hold the result for `hold` cycles, then consume.
   task automatic do_op(input logic [3:0] t, input logic [63:0] a, input logic [63:0] b,
                        input int hold, output logic [63:0] got);
      logic [63:0]      exp_r;
      int               exp_lat;
      int               lat;
      logic [4:0]       trd;
      logic             tnw;
      logic [TAG_W-1:0] trob;
      exp_r   = ref_result(t, a, b);
      exp_lat = ref_lat(t, a, b);
      trd     = 5'($urandom);
      tnw     = 1'($urandom);
      trob    = TAG_W'($urandom);
      got     = 64'd0;
      @(negedge clock);
      check_eq("in_ready_idle", 64'(bus.in_ready), 64'd1);
      bus.in_valid    = 1'b1;
      bus.muldiv_type = t;
      bus.src1        = a;
      bus.src2        = b;
      bus.rd          = trd;
      bus.need_to_wb  = tnw;
      bus.rob_idx     = trob;
      bus.out_ready   = 1'b0;
      @(negedge clock);
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(negedge clock);
         lat++;
      end
      check_eq($sformatf("latency t=%0d", t), 64'(lat), 64'(exp_lat));
      if (bus.out_valid !== 1'b1) begin
         flush = 1'b1;
         @(negedge clock);
         flush = 1'b0;
      end else begin
         got = bus.result;
         check_eq($sformatf("result t=%0d a=%h b=%h", t, a, b), bus.result, exp_r);
         check_eq("tags", 64'({bus.out_rd, bus.out_need_to_wb, bus.out_rob_idx}),
                  64'({trd, tnw, trob}));
         for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.rob_idx  = ~trob;
            @(negedge clock);
            check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check_eq("hold_result", bus.result, exp_r);
            check_eq("hold_rob", 64'(bus.out_rob_idx), 64'(trob));
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         @(negedge clock);
         bus.out_ready = 1'b0;
         check_eq("consumed", 64'({bus.out_valid, bus.in_ready}), 64'b01);
      end
   endtask

   initial begin
      logic [63:0] got;
      int          seen;
      reset           = 1'b1;
      flush           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.muldiv_type = 4'd0;
      bus.src1        = '0;
      bus.src2        = '0;
      bus.rd          = '0;
      bus.need_to_wb  = 1'b0;
      bus.rob_idx     = '0;
      bus.out_ready   = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check_eq("rst_valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'b01);
      check_eq("rst_result", bus.result, 64'd0);
      check_eq("rst_tags", 64'({bus.out_rd, bus.out_need_to_wb, bus.out_rob_idx}), 64'd0);

      do_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, got);
      check_eq("mul_7x-3", got, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op(4'd4, 64'd100, 64'd7, 0, got);
      check_eq("div_100_7", got, 64'd14);
      do_op(4'd6, 64'd100, 64'd7, 0, got);
      check_eq("rem_100_7", got, 64'd2);
      do_op(4'd7, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, got);
      check_eq("remu_-100_7", got, 64'd0);
      do_op(4'd4, 64'd12345, 64'd0, 0, got);
      check_eq("div_by_zero", got, 64'hFFFF_FFFF_FFFF_FFFF);
      do_op(4'd14, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, got);
      check_eq("remw_ovf", got, 64'd0);
      do_op(4'd12, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, got);
      check_eq("divw_ovf", got, 64'hFFFF_FFFF_8000_0000);
      do_op(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, got);
      check_eq("mulhu_ones", got, 64'hFFFF_FFFF_FFFF_FFFE);
      do_op(4'd8, 64'h7FFF_FFFF, 64'd2, 5, got);
      check_eq("mulw_wrap", got, 64'hFFFF_FFFF_FFFF_FFFE);

      // Flush mid-divide: nothing may come out, unit returns to idle.
      @(negedge clock);
      bus.in_valid = 1'b1; bus.muldiv_type = 4'd4; bus.src1 = 64'd100; bus.src2 = 64'd7;
      @(negedge clock);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clock);
      check_eq("div_busy", 64'(bus.in_ready), 64'd0);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check_eq("flush_in_ready", 64'(bus.in_ready), 64'd1);
      seen = 0;
      repeat (80) begin
         if (bus.out_valid === 1'b1) seen++;
         @(negedge clock);
      end
      check_eq("flush_no_valid", 64'(seen), 64'd0);
      do_op(4'd0, 64'd6, 64'd9, 0, got);
      check_eq("post_flush_mul", got, 64'd54);

      // Flush with a pending result, with and without out_ready.
      for (int v = 0; v < 2; v++) begin
         @(negedge clock);
         bus.in_valid = 1'b1; bus.muldiv_type = 4'd0; bus.src1 = 64'd3; bus.src2 = 64'd5;
         @(negedge clock);
         bus.in_valid = 1'b0;
         repeat (MUL_LAT - 1) @(negedge clock);
         check_eq("done_valid", 64'(bus.out_valid), 64'd1);
         flush = 1'b1;
         bus.out_ready = 1'(v);
         @(negedge clock);
         flush = 1'b0;
         bus.out_ready = 1'b0;
         check_eq("done_flush", 64'({bus.out_valid, bus.in_ready}), 64'b01);
      end

      // Flush beats in_valid in the same cycle.
      @(negedge clock);
      bus.in_valid = 1'b1; bus.muldiv_type = 4'd4; bus.src2 = 64'd0; flush = 1'b1;
      @(negedge clock);
      bus.in_valid = 1'b0; flush = 1'b0;
      check_eq("flush_no_accept", 64'(bus.in_ready), 64'd1);
      repeat (3) @(negedge clock);
      check_eq("flush_no_accept_valid", 64'(bus.out_valid), 64'd0);

      // Reset mid-divide clears state and outputs.
      @(negedge clock);
      bus.in_valid = 1'b1; bus.muldiv_type = 4'd5; bus.src1 = 64'd999; bus.src2 = 64'd10;
      bus.rob_idx = 6'd33;
      @(negedge clock);
      bus.in_valid = 1'b0;
      repeat (20) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_eq("rst_mid_valid_ready", 64'({bus.out_valid, bus.in_ready}), 64'b01);
      check_eq("rst_mid_result", bus.result, 64'd0);
      check_eq("rst_mid_rob", 64'(bus.out_rob_idx), 64'd0);

      for (int n = 0; n < 250; n++)
         do_op(4'($urandom), rand_operand(), rand_operand(), $urandom_range(0, 2), got);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
